// File: rtl/sram_responder.sv
// Clocked model of an asynchronous SRAM seen from the controller's PHY pins, with a backdoor port.
// Define SRAM_RESP_STATS_EN to build the front-door read/write counters.
module sram_responder #(
    parameter int DW     = 8,
    parameter int AW     = 19,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1,
    parameter int WR_DLY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] sram_addr,
    input  logic          sram_ce_n,
    input  logic          sram_we_n,
    input  logic          sram_oe_n,
    input  logic [DW-1:0] sram_dq_wr,
    output logic [DW-1:0] sram_dq_rd,
    output logic          sram_dq_oe,
    input  logic          bd_en,
    input  logic          bd_we,
    input  logic [AW-1:0] bd_addr,
    input  logic [DW-1:0] bd_wdata,
    output logic [DW-1:0] bd_rdata,
    output logic          addr_err,
    output logic          bd_collision,
    output logic [31:0]   rd_count,
    output logic [31:0]   wr_count
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];

    logic          wr_cyc, rd_cyc;
    logic          in_range, bd_in_range;
    logic          commit_vld;
    logic [AW-1:0] commit_addr;
    logic [DW-1:0] commit_data;
    logic          bd_hit;
    logic [DW-1:0] rd_word;

    assign wr_cyc      = ~sram_ce_n & ~sram_we_n;
    assign rd_cyc      = ~sram_ce_n &  sram_we_n & ~sram_oe_n;
    assign sram_dq_oe  = rd_cyc;
    assign in_range    = {1'b0, sram_addr} < (AW+1)'(DEPTH);
    assign bd_in_range = {1'b0, bd_addr}   < (AW+1)'(DEPTH);

    // Commit stage: the single point where front-door data lands in memory.
    generate
        if (WR_DLY == 0) begin : g_wr_direct
            assign commit_vld  = wr_cyc & in_range & ~rst;
            assign commit_addr = sram_addr;
            assign commit_data = sram_dq_wr;
        end else begin : g_wr_delayed
            logic          pend_vld;
            logic [AW-1:0] pend_addr;

            always_ff @(posedge clk) begin
                if (rst) begin
                    pend_vld <= 1'b0;
                end else begin
                    pend_vld <= wr_cyc & in_range;
                end
                if (wr_cyc) pend_addr <= sram_addr;
            end

            assign commit_vld  = pend_vld & ~rst;
            assign commit_addr = pend_addr;
            assign commit_data = sram_dq_wr;
        end
    endgenerate

    assign bd_hit = commit_vld && (commit_addr == bd_addr);

    always_ff @(posedge clk) begin
        if (commit_vld) mem[commit_addr[IW-1:0]] <= commit_data;
        if (bd_en && bd_we && bd_in_range && !bd_hit) mem[bd_addr[IW-1:0]] <= bd_wdata;
    end

    // Reads see a same-edge commit so the controller never gets a stale word.
    always_comb begin
        rd_word = '0;
        if (in_range) begin
            if (commit_vld && (commit_addr == sram_addr)) rd_word = commit_data;
            else                                           rd_word = mem[sram_addr[IW-1:0]];
        end
    end

    logic          vld_pipe  [RD_LAT];
    logic [DW-1:0] data_pipe [RD_LAT];

    generate
        for (genvar k = 0; k < RD_LAT; k++) begin : g_rd
            if (k == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) begin
                        vld_pipe[0]  <= 1'b0;
                        data_pipe[0] <= '0;
                    end else begin
                        vld_pipe[0] <= rd_cyc;
                        if (rd_cyc) data_pipe[0] <= rd_word;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (rst) begin
                        vld_pipe[k]  <= 1'b0;
                        data_pipe[k] <= '0;
                    end else begin
                        vld_pipe[k] <= vld_pipe[k-1];
                        if (vld_pipe[k-1]) data_pipe[k] <= data_pipe[k-1];
                    end
                end
            end
        end
    endgenerate

    // Last stage only loads on a completing read, so the pins hold otherwise.
    assign sram_dq_rd = data_pipe[RD_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            bd_rdata     <= '0;
            addr_err     <= 1'b0;
            bd_collision <= 1'b0;
        end else begin
            addr_err     <= (wr_cyc | rd_cyc) & ~in_range;
            bd_collision <= bd_en & bd_we & bd_hit;
            if (bd_en && !bd_we) begin
                if (!bd_in_range) bd_rdata <= '0;
                else if (bd_hit)  bd_rdata <= commit_data;
                else              bd_rdata <= mem[bd_addr[IW-1:0]];
            end
        end
    end

`ifdef SRAM_RESP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_cyc) rd_count <= rd_count + 32'd1;
            if (wr_cyc) wr_count <= wr_count + 32'd1;
        end
    end
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench: two responders (RD_LAT=1 and RD_LAT=3, both WR_DLY=1) share one pin stimulus.
module tb_sram_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [18:0] sram_addr;
    logic        sram_ce_n, sram_we_n, sram_oe_n;
    logic [7:0]  sram_dq_wr;
    logic        bd_en, bd_we;
    logic [18:0] bd_addr;
    logic [7:0]  bd_wdata;

    logic [7:0]  rd1, bdr1, rd3, bdr3;
    logic        oe1, aerr1, col1, oe3, aerr3, col3;
    logic [31:0] rc1, wc1, rc3, wc3;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef SRAM_RESP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    always #5 clk = ~clk;

    sram_responder #(.DW(8), .AW(19), .DEPTH(1024), .RD_LAT(1), .WR_DLY(1)) u1 (
        .clk(clk), .rst(rst), .sram_addr(sram_addr), .sram_ce_n(sram_ce_n),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_dq_wr(sram_dq_wr),
        .sram_dq_rd(rd1), .sram_dq_oe(oe1), .bd_en(bd_en), .bd_we(bd_we),
        .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bdr1), .addr_err(aerr1),
        .bd_collision(col1), .rd_count(rc1), .wr_count(wc1));

    sram_responder #(.DW(8), .AW(19), .DEPTH(1024), .RD_LAT(3), .WR_DLY(1)) u3 (
        .clk(clk), .rst(rst), .sram_addr(sram_addr), .sram_ce_n(sram_ce_n),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_dq_wr(sram_dq_wr),
        .sram_dq_rd(rd3), .sram_dq_oe(oe3), .bd_en(bd_en), .bd_we(bd_we),
        .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bdr3), .addr_err(aerr3),
        .bd_collision(col3), .rd_count(rc3), .wr_count(wc3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sram_ce_n = 1'b1; sram_we_n = 1'b1; sram_oe_n = 1'b1;
        bd_en = 1'b0; bd_we = 1'b0;
    endtask

    task automatic fwr(input logic [18:0] a);
        idle();
        sram_addr = a; sram_ce_n = 1'b0; sram_we_n = 1'b0;
    endtask

    task automatic frd(input logic [18:0] a);
        idle();
        sram_addr = a; sram_ce_n = 1'b0; sram_oe_n = 1'b0;
    endtask

    task automatic bdw(input logic [18:0] a, input logic [7:0] d);
        bd_en = 1'b1; bd_we = 1'b1; bd_addr = a; bd_wdata = d;
    endtask

    task automatic bdr(input logic [18:0] a);
        bd_en = 1'b1; bd_we = 1'b0; bd_addr = a;
    endtask

    initial begin
        idle();
        sram_addr = '0; sram_dq_wr = '0; bd_addr = '0; bd_wdata = '0;
        rst = 1'b1;
        tick(); tick();
        chk("rst_rd1", 32'(rd1), 32'h0);
        chk("rst_rd3", 32'(rd3), 32'h0);
        chk("rst_bdr", 32'(bdr1), 32'h0);
        chk("rst_aerr", 32'(aerr1), 32'h0);
        chk("rst_col", 32'(col1), 32'h0);
        chk("rst_rc", rc1, 32'h0);
        chk("rst_wc", wc1, 32'h0);
        rst = 1'b0;
        tick();

        // basic write (data one cycle late) then read
        fwr(19'h10); #1;
        chk("oe_on_write", 32'(oe1), 32'h0);
        tick();
        idle(); sram_dq_wr = 8'hA5; #1;
        chk("oe_on_commit", 32'(oe1), 32'h0);
        tick();
        frd(19'h10); #1;
        chk("oe_on_read", 32'(oe1), 32'h1);
        tick();
        chk("basic_rd", 32'(rd1), 32'hA5);
        idle(); #1;
        chk("oe_after_read", 32'(oe1), 32'h0);

        // forwarding: read in the commit cycle
        fwr(19'h5); tick();
        frd(19'h5); sram_dq_wr = 8'h3C; tick();
        chk("fwd_rd", 32'(rd1), 32'h3C);
        idle();

        // backdoor preload, then back-to-back reads through RD_LAT=3
        for (int i = 0; i < 4; i++) begin
            bdw(19'(i), 8'(i * 8'h11)); tick();
        end
        idle();
        frd(19'h0); tick();
        frd(19'h1); tick();
        chk("lat3_not_yet", 32'(rd3), 32'h3C);
        chk("lat1_rd1", 32'(rd1), 32'h11);
        frd(19'h2); tick();
        chk("lat3_t3", 32'(rd3), 32'h00);
        frd(19'h3); tick();
        chk("lat3_t4", 32'(rd3), 32'h11);
        chk("lat1_rd3", 32'(rd1), 32'h33);
        idle(); tick();
        chk("lat3_t5", 32'(rd3), 32'h22);
        tick();
        chk("lat3_t6", 32'(rd3), 32'h33);
        tick();
        chk("lat3_hold", 32'(rd3), 32'h33);
        bdr(19'h2); tick();
        chk("bd_rd2", 32'(bdr1), 32'h22);
        idle();

        // out-of-range write and read
        fwr(19'd1024); tick();
        chk("aerr_wr", 32'(aerr1), 32'h1);
        idle(); sram_dq_wr = 8'h77; tick();
        chk("aerr_clr", 32'(aerr1), 32'h0);
        frd(19'd1024); tick();
        chk("aerr_rd", 32'(aerr1), 32'h1);
        chk("oor_rd", 32'(rd1), 32'h00);
        idle(); bdr(19'h0); tick();
        chk("oor_no_alias", 32'(bdr1), 32'h00);
        chk("aerr_clr2", 32'(aerr1), 32'h0);
        idle();

        // backdoor write collides with a front-door commit
        fwr(19'h7); tick();
        idle(); sram_dq_wr = 8'h99; bdw(19'h7, 8'h55); tick();
        chk("col_pulse", 32'(col1), 32'h1);
        idle(); tick();
        chk("col_clr", 32'(col1), 32'h0);
        bdr(19'h7); tick();
        chk("col_bd_rd", 32'(bdr1), 32'h99);
        frd(19'h7); tick();
        chk("col_fd_rd", 32'(rd1), 32'h99);
        fwr(19'h8); tick();
        idle(); sram_dq_wr = 8'h42; bdr(19'h8); tick();
        chk("bd_rd_commit", 32'(bdr1), 32'h42);
        idle();

        // reset with a write pending
        rst = 1'b1; tick(); rst = 1'b0;
        bdw(19'd22, 8'h5A); tick();
        fwr(19'd20); tick();
        fwr(19'd21); sram_dq_wr = 8'hD0; tick();
        frd(19'd20); sram_dq_wr = 8'hD1; tick();
        chk("pipe_rd20", 32'(rd1), 32'hD0);
        frd(19'd21); tick();
        chk("pipe_rd21", 32'(rd1), 32'hD1);
        fwr(19'd22); tick();
        chk("pre_rst_wc", wc1, STATS ? 32'd3 : 32'd0);
        chk("pre_rst_rc", rc1, STATS ? 32'd2 : 32'd0);
        chk("pre_rst_rd3", 32'(rd3), 32'hD0);
        idle(); sram_dq_wr = 8'hEE; rst = 1'b1; tick();
        chk("rst_wc2", wc1, 32'h0);
        chk("rst_rc2", rc1, 32'h0);
        chk("rst_rd1b", 32'(rd1), 32'h0);
        chk("rst_rd3b", 32'(rd3), 32'h0);
        rst = 1'b0; tick(); tick(); tick();
        chk("rst_drop_rd", 32'(rd3), 32'h0);
        bdr(19'd22); tick();
        chk("rst_pend_cancel", 32'(bdr1), 32'h5A);
        idle(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Synthesizable, clocked model of an external asynchronous SRAM as seen from the SRAM PHY pins driven by the SRAM controller.
- Used as the device end of the SRAM pin interface in FPGA loopback builds and in simulation benches, in place of the board SRAM.
- Stores DEPTH x DW words, honours the controller's one-cycle-delayed write data, and returns read data after a configurable latency.
- Provides a backdoor port for preload/inspection and error flags for protocol checking.

Parameters:
- DW, 8: data width.
- AW, 19: address width.
- DEPTH, 1024: implemented words; must be <= 2**AW.
- RD_LAT, 1: read latency in cycles; must be >= 1.
- WR_DLY, 1: cycles between the write strobe and valid write data on sram_dq_wr; legal values 0 or 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- sram_addr  in  AW  address from controller
- sram_ce_n  in  1  chip enable, active-low
- sram_we_n  in  1  write enable, active-low
- sram_oe_n  in  1  output enable, active-low
- sram_dq_wr  in  DW  write data from controller
- sram_dq_rd  out  DW  read data to controller
- sram_dq_oe  out  1  device-drive enable for the top-level tristate
- bd_en  in  1  backdoor access strobe
- bd_we  in  1  backdoor write (1) / read (0)
- bd_addr  in  AW  backdoor address
- bd_wdata  in  DW  backdoor write data
- bd_rdata  out  DW  backdoor read data
- addr_err  out  1  pulse: front-door access with address >= DEPTH
- bd_collision  out  1  pulse: backdoor write lost to a front-door commit
- rd_count  out  32  front-door read counter (optional feature)
- wr_count  out  32  front-door write counter (optional feature)

Behaviour:
- Cycle classification, sampled each clk edge:
  - Write cycle: ce_n=0 and we_n=0. we_n overrides oe_n.
  - Read cycle: ce_n=0, we_n=1, oe_n=0.
  - Otherwise idle.
- sram_dq_oe: combinational, high exactly on a read cycle.
- Write path:
  - WR_DLY=0: mem[addr] <= sram_dq_wr at the write-cycle edge.
  - WR_DLY=1: the address is captured into a pending register at the write-cycle edge. sram_dq_wr is committed to that address at the next edge, regardless of the pin state in that cycle.
  - Back-to-back writes pipeline: one commit per cycle, in order.
- Read path:
  - mem[addr] is sampled at the read-cycle edge and shifted through RD_LAT registers. sram_dq_rd updates RD_LAT edges after the read cycle.
  - sram_dq_rd holds its last value when no read completes.
- Forwarding: a read whose address matches a write committing at the same edge returns the committing data, not the stale word.
- Out-of-range addresses (addr >= DEPTH):
  - Writes are dropped.
  - Reads return 0 after RD_LAT.
  - addr_err pulses for 1 cycle at the access edge. For WR_DLY=1 writes, this is the strobe edge.
- Backdoor:
  - bd_rdata is registered, with 1-cycle latency.
  - A backdoor write to the same address as a front-door commit in the same cycle is discarded: the front door wins, and bd_collision pulses 1 cycle.
  - A backdoor read in a commit cycle to the same address returns the new data.
- Reset:
  - sram_dq_rd=0, bd_rdata=0, addr_err=0, bd_collision=0, counters=0.
  - Read pipeline cleared; a pending WR_DLY write is cancelled and not committed.
  - Memory contents are not cleared.
  - A read issued fewer than RD_LAT cycles before reset never appears on sram_dq_rd.

Optional Feature:
- Macro SRAM_RESP_STATS_EN.
- Defined:
  - rd_count increments once per read cycle; wr_count increments once per write cycle (strobe edge), in-range or not.
  - Both wrap from 2**32-1 to 0 and clear on rst.
- Undefined: rd_count and wr_count are tied to 0 and no counter logic is built.

Test Plan:
- Basic read/write (WR_DLY=1, RD_LAT=1):
  - Stimulus: write strobe to addr 0x10, with sram_dq_wr=0xA5 driven the next cycle; then read 0x10.
  - Required: sram_dq_rd=0xA5 one cycle after the read; sram_dq_oe high only during the read cycle.
- Forwarding:
  - Stimulus: write 0x3C to addr 5, then in the following cycle read addr 5 (the cycle its data is committed).
  - Required: sram_dq_rd=0x3C.
- Latency and back-to-back reads (RD_LAT=3):
  - Stimulus: preload addrs 0..3 = 0x00,0x11,0x22,0x33 via backdoor; read 0..3 on consecutive cycles.
  - Required: values appear on cycles t+3..t+6 in order; sram_dq_rd holds 0x33 afterwards.
- Range check (DEPTH=1024):
  - Stimulus: write 0x77 to addr 1024, then read addr 1024.
  - Required: addr_err pulses twice; read returns 0x00; backdoor read of addr 0 is unchanged.
- Backdoor collision:
  - Stimulus: front-door commit 0x99 and backdoor write 0x55 to addr 7 in the same cycle.
  - Required: bd_collision=1 for one cycle; mem[7] reads 0x99.
- Reset mid-operation with SRAM_RESP_STATS_EN:
  - Stimulus: 3 writes and 2 reads, then rst asserted while a write is pending.
  - Required: before reset wr_count=3, rd_count=2; after reset both counters=0, sram_dq_rd=0, and the pending address is unchanged.
